// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed 8N1 UART transmitter.
package fifo_uart_pkg;

   localparam int unsigned UART_DATA_BITS  = 8;
   localparam int unsigned UART_BIT_IDX_W  = 3;
   localparam logic        UART_IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_START = 3'd3,
      ST_DATA  = 3'd4,
      ST_STOP  = 3'd5
   } uart_tx_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: tick at terminal count, pre_tick_c one cycle earlier.
module baud_tick_gen #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick,
   output logic pre_tick_c
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = '0;
      if (en) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // pre_tick_c lets the parent register outputs that must coincide with tick
   assign tick       = en && (cnt_q == CNT_LAST);
   assign pre_tick_c = en && (cnt_q == CNT_PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO one byte per 8N1 frame onto a serial line.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned DATA_W       = UART_DATA_BITS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fifo_empty,
   output logic              fifo_rd_en,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              tx,
   output logic              busy,
   output logic              tx_done
);

   localparam logic [UART_BIT_IDX_W-1:0] BIT_LAST = UART_BIT_IDX_W'(DATA_W - 1);

   uart_tx_state_t            state_q, state_d;
   logic [DATA_W-1:0]         shift_q, shift_d;
   logic [UART_BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
   logic                      tx_q, tx_d;
   logic                      fifo_rd_en_q, fifo_rd_en_d;
   logic                      busy_q, busy_d;
   logic                      tx_done_q, tx_done_d;
   logic                      baud_en;
   logic                      tick;
   logic                      pre_tick;

   assign baud_en = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);

   baud_tick_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (baud_en),
      .tick      (tick),
      .pre_tick_c(pre_tick)
   );

   // Outputs are registered from next-state values so they line up with state_q
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      tx_done_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            shift_d   = fifo_data;
            bit_idx_d = '0;
            state_d   = ST_START;
         end
         ST_START: begin
            if (tick) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (tick) begin
               shift_d   = shift_q >> 1;
               bit_idx_d = bit_idx_q + UART_BIT_IDX_W'(1);
               if (bit_idx_q == BIT_LAST) begin
                  state_d = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            tx_done_d = pre_tick;
            if (tick) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      fifo_rd_en_d = (state_d == ST_FETCH);
      busy_d       = (state_d != ST_IDLE);
      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shift_d[0];
         default:  tx_d = UART_IDLE_LEVEL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         shift_q      <= '0;
         bit_idx_q    <= '0;
         tx_q         <= UART_IDLE_LEVEL;
         fifo_rd_en_q <= 1'b0;
         busy_q       <= 1'b0;
         tx_done_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bit_idx_q    <= bit_idx_d;
         tx_q         <= tx_d;
         fifo_rd_en_q <= fifo_rd_en_d;
         busy_q       <= busy_d;
         tx_done_q    <= tx_done_d;
      end
   end

   assign tx         = tx_q;
   assign fifo_rd_en = fifo_rd_en_q;
   assign busy       = busy_q;
   assign tx_done    = tx_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4 and a behavioural FIFO.
module tb_fifo_uart_tx;

   localparam int unsigned CPB = 4;

   logic       clk;
   logic       rst_n;
   logic       fifo_empty;
   logic       fifo_rd_en;
   logic [7:0] fifo_data;
   logic       tx;
   logic       busy;
   logic       tx_done;

   logic       push_req;
   logic [7:0] push_byte;
   logic       empty_glitch;
   logic [7:0] fifo_q[$];
   int         fifo_level;
   int         pop_cnt;
   int         n_checks;
   int         n_err;

   fifo_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .DATA_W      (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en),
      .fifo_data (fifo_data),
      .tx        (tx),
      .busy      (busy),
      .tx_done   (tx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO model: data_out valid the cycle after a sampled pop
   always @(posedge clk) begin
      if (push_req) fifo_q.push_back(push_byte);
      if (fifo_rd_en) begin
         pop_cnt = pop_cnt + 1;
         if (fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
      end
      fifo_level <= fifo_q.size();
   end

   assign fifo_empty = (fifo_level == 0) && !empty_glitch;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks = n_checks + 1;
      assert (obs === exp) else begin
         n_err = n_err + 1;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] v);
      push_byte = v;
      push_req  = 1'b1;
      @(negedge clk);
      push_req  = 1'b0;
   endtask

   // Waits for a start bit, captures 40 line samples and checks them against an 8N1 frame of b
   task automatic frame(input logic [7:0] b, input string tag, input int push_at,
                        input logic [7:0] pb, input int glitch_at, output int gap);
      logic [39:0] obs;
      logic [39:0] exp;
      logic        bitv;
      logic        found;
      int          done_n;
      int          done_pos;
      gap      = 0;
      found    = 1'b0;
      done_n   = 0;
      done_pos = -1;
      obs      = '0;
      for (int k = 0; k < 300 && !found; k++) begin
         @(negedge clk);
         if (tx === 1'b0) found = 1'b1;
         else gap = gap + 1;
      end
      chk({tag, "_start_seen"}, 64'(found), 64'(1));
      if (!found) return;
      push_byte = pb;
      for (int i = 0; i < 40; i++) begin
         if (i > 0) @(negedge clk);
         obs[i] = tx;
         if (tx_done === 1'b1) begin
            done_n   = done_n + 1;
            done_pos = i;
         end
         push_req     = (i == push_at);
         empty_glitch = (i == glitch_at);
      end
      push_req     = 1'b0;
      empty_glitch = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (k == 0) bitv = 1'b0;
         else if (k == 9) bitv = 1'b1;
         else bitv = b[k-1];
         for (int j = 0; j < 4; j++) exp[k*4+j] = bitv;
      end
      chk({tag, "_bits"}, 64'(obs), 64'(exp));
      chk({tag, "_done_cnt"}, 64'(done_n), 64'(1));
      chk({tag, "_done_pos"}, 64'(done_pos), 64'(39));
   endtask

   initial begin
      int gap;
      int pops0;
      logic ok_tx;
      logic ok_busy;

      n_checks     = 0;
      n_err        = 0;
      pop_cnt      = 0;
      push_req     = 1'b0;
      push_byte    = 8'h00;
      empty_glitch = 1'b0;
      fifo_level   = 0;
      fifo_data    = 8'h00;
      rst_n        = 1'b0;

      // Reset idle
      repeat (3) @(negedge clk);
      chk("rst_tx", 64'(tx), 64'(1));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_rd_en", 64'(fifo_rd_en), 64'(0));
      chk("rst_tx_done", 64'(tx_done), 64'(0));
      rst_n   = 1'b1;
      ok_tx   = 1'b1;
      ok_busy = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) ok_tx = 1'b0;
         if (busy !== 1'b0) ok_busy = 1'b0;
      end
      chk("idle_tx_high", 64'(ok_tx), 64'(1));
      chk("idle_busy_low", 64'(ok_busy), 64'(0) + 64'(1));
      chk("idle_no_pop", 64'(pop_cnt), 64'(0));

      // Single byte A1
      push(8'hA1);
      frame(8'hA1, "single_a1", -1, 8'h00, -1, gap);
      chk("single_pops", 64'(pop_cnt), 64'(1));
      repeat (2) @(negedge clk);
      chk("single_busy_after", 64'(busy), 64'(0));

      // Three queued bytes, back to back
      repeat (5) @(negedge clk);
      push(8'hA1);
      push(8'hB2);
      push(8'hC3);
      frame(8'hA1, "q3_a1", -1, 8'h00, -1, gap);
      frame(8'hB2, "q3_b2", -1, 8'h00, -1, gap);
      chk("q3_gap_ab", 64'(gap), 64'(3));
      frame(8'hC3, "q3_c3", -1, 8'h00, -1, gap);
      chk("q3_gap_bc", 64'(gap), 64'(3));
      chk("q3_pops", 64'(pop_cnt), 64'(4));
      repeat (3) @(negedge clk);
      chk("q3_fifo_empty", 64'(fifo_level), 64'(0));

      // Late arrival during DATA of an A1 frame
      repeat (5) @(negedge clk);
      push(8'hA1);
      frame(8'hA1, "late_a1", 12, 8'hD4, -1, gap);
      chk("late_no_early_pop", 64'(pop_cnt), 64'(5));
      frame(8'hD4, "late_d4", -1, 8'h00, -1, gap);
      chk("late_gap", 64'(gap), 64'(3));
      chk("late_pops", 64'(pop_cnt), 64'(6));

      // fifo_empty glitch during STOP is ignored
      repeat (5) @(negedge clk);
      push(8'h5A);
      frame(8'h5A, "glitch_5a", -1, 8'h00, 37, gap);
      repeat (20) @(negedge clk);
      chk("glitch_pops", 64'(pop_cnt), 64'(7));
      chk("glitch_busy", 64'(busy), 64'(0));
      chk("glitch_tx", 64'(tx), 64'(1));

      // Reset during data bit 3 of B2, then C3 goes out cleanly
      push(8'hB2);
      push(8'hC3);
      ok_tx = 1'b0;
      for (int k = 0; k < 300 && !ok_tx; k++) begin
         if (tx === 1'b0) ok_tx = 1'b1;
         else @(negedge clk);
      end
      chk("mid_start_seen", 64'(ok_tx), 64'(1));
      repeat (17) @(negedge clk);
      chk("mid_busy_before", 64'(busy), 64'(1));
      pops0 = pop_cnt;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tx", 64'(tx), 64'(1));
      chk("mid_rst_busy", 64'(busy), 64'(0));
      chk("mid_rst_rd_en", 64'(fifo_rd_en), 64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      frame(8'hC3, "mid_c3", -1, 8'h00, -1, gap);
      chk("mid_pops", 64'(pop_cnt), 64'(pops0 + 1));
      repeat (3) @(negedge clk);
      chk("mid_fifo_empty", 64'(fifo_level), 64'(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
